wb_regfile: RTL and testbench

Writeback stage and integer register file of the 5-stage 64-bit pipeline. Consumes the MEM/WB pipeline register outputs, selects the writeback value (memory load data or ALU result), and commits it to a 32 × 64-bit register file. It serves the two decode-stage read ports with same-cycle write-to-read bypass, so no separate WB→ID forwarding path is needed. A committed-write counter is kept for debug and bench checking.

---
 rtl/wb_regfile_pkg.sv | 15 +
 rtl/wb_regfile_rf.sv | 38 +++
 rtl/wb_regfile.sv | 65 ++++++
 tb/tb_wb_regfile.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback stage and the integer register file.
package wb_regfile_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // True when an address names the hardwired-zero register.
    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
        return addr == ZERO_REG;
    endfunction

endpackage

// File: rtl/wb_regfile_rf.sv
// 32-entry register file with two asynchronous read ports and one write port.
// x0 is never written and always reads as zero.
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = XLEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Storage update: clear everything on reset, otherwise write any register except x0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && !is_zero_reg(waddr)) begin
            regs[waddr] <= wdata;
        end
    end

    // Asynchronous reads with x0 forced to zero.
    always_comb begin
        rdata1 = is_zero_reg(raddr1) ? '0 : regs[raddr1];
        rdata2 = is_zero_reg(raddr2) ? '0 : regs[raddr2];
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects load data or ALU result, commits it to the register
// file, bypasses the committing value to both decode read ports in the same
// cycle, and counts committed writes.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int XLEN  = wb_regfile_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic                  MemtoReg,
    input  logic [XLEN-1:0]       DataOut,
    input  logic [XLEN-1:0]       AluOut,
    input  logic [REG_ADDR_W-1:0] Rd,
    input  logic [REG_ADDR_W-1:0] Rs1,
    input  logic [REG_ADDR_W-1:0] Rs2,
    output logic [XLEN-1:0]       ReadData1,
    output logic [XLEN-1:0]       ReadData2,
    output logic [XLEN-1:0]       WbData,
    output logic [CNT_W-1:0]      WbCount
);

    logic            commit;
    logic [XLEN-1:0] rf_data1;
    logic [XLEN-1:0] rf_data2;

    // Writeback select and commit qualification; reset drops the in-flight write.
    always_comb begin
        WbData = MemtoReg ? DataOut : AluOut;
        commit = RegWrite && !is_zero_reg(Rd) && !reset;
    end

    regfile_2r1w #(
        .DATA_W (XLEN)
    ) u_rf (
        .clk    (clk),
        .reset  (reset),
        .we     (commit),
        .waddr  (Rd),
        .wdata  (WbData),
        .raddr1 (Rs1),
        .raddr2 (Rs2),
        .rdata1 (rf_data1),
        .rdata2 (rf_data2)
    );

    // Same-cycle write-to-read bypass; commit already excludes x0, and the
    // register file masks x0 on the non-bypass path.
    always_comb begin
        ReadData1 = (commit && (Rs1 == Rd)) ? WbData : rf_data1;
        ReadData2 = (commit && (Rs2 == Rd)) ? WbData : rf_data2;
    end

    // Committed-write counter, wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            WbCount <= '0;
        end else if (commit) begin
            WbCount <= WbCount + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus pushes expected values into a queue,
// a negedge monitor pops and compares them against the live outputs.
module tb_wb_regfile;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            RegWrite = 1'b0;
    logic            MemtoReg = 1'b0;
    logic [XLEN-1:0] DataOut = '0;
    logic [XLEN-1:0] AluOut = '0;
    logic [4:0]      Rd = '0;
    logic [4:0]      Rs1 = '0;
    logic [4:0]      Rs2 = '0;

    logic [XLEN-1:0] ReadData1, ReadData2, WbData;
    logic [31:0]     WbCount;
    logic [XLEN-1:0] ReadData1_n, ReadData2_n, WbData_n;
    logic [3:0]      WbCount_n;

    always #5 clk = ~clk;

    wb_regfile #(.XLEN(XLEN), .CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .MemtoReg  (MemtoReg),
        .DataOut   (DataOut),
        .AluOut    (AluOut),
        .Rd        (Rd),
        .Rs1       (Rs1),
        .Rs2       (Rs2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .WbData    (WbData),
        .WbCount   (WbCount)
    );

    // Narrow-counter instance so the wrap boundary is reachable in a short run.
    wb_regfile #(.XLEN(XLEN), .CNT_W(4)) dut_n (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .MemtoReg  (MemtoReg),
        .DataOut   (DataOut),
        .AluOut    (AluOut),
        .Rd        (Rd),
        .Rs1       (Rs1),
        .Rs2       (Rs2),
        .ReadData1 (ReadData1_n),
        .ReadData2 (ReadData2_n),
        .WbData    (WbData_n),
        .WbCount   (WbCount_n)
    );

    localparam int S_RD1  = 0;
    localparam int S_RD2  = 1;
    localparam int S_WB   = 2;
    localparam int S_CNT  = 3;
    localparam int S_CNTN = 4;
    localparam int S_RD1N = 5;
    localparam int S_RD2N = 6;
    localparam int S_WBN  = 7;

    typedef struct {
        int              sel;
        logic [XLEN-1:0] exp;
        string           name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic drive(input logic rst, input logic rw, input logic m2r,
                         input logic [XLEN-1:0] d, input logic [XLEN-1:0] a,
                         input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        reset    = rst;
        RegWrite = rw;
        MemtoReg = m2r;
        DataOut  = d;
        AluOut   = a;
        Rd       = rd;
        Rs1      = r1;
        Rs2      = r2;
    endtask

    task automatic expect_val(input int sel, input logic [XLEN-1:0] v, input string nm);
        exp_t e;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so every queued expectation for this
    // cycle is compared mid-cycle on the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t            e;
            logic [XLEN-1:0] act;
            e = exp_q.pop_front();
            case (e.sel)
                S_RD1:   act = ReadData1;
                S_RD2:   act = ReadData2;
                S_WB:    act = WbData;
                S_CNT:   act = {32'd0, WbCount};
                S_CNTN:  act = {60'd0, WbCount_n};
                S_RD1N:  act = ReadData1_n;
                S_RD2N:  act = ReadData2_n;
                default: act = WbData_n;
            endcase
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset edge, then sweep every address on both ports.
        drive(1'b0, 1'b0, 1'b0, '0, '0, 5'd0, 5'd0, 5'd31);
        expect_val(S_CNT, 64'd0, "cnt_after_reset");
        for (int i = 0; i < 32; i++) begin
            if (i != 0) drive(1'b0, 1'b0, 1'b0, '0, '0, 5'd0, 5'(i), 5'(31 - i));
            expect_val(S_RD1, 64'd0, "rd1_after_reset");
            expect_val(S_RD2, 64'd0, "rd2_after_reset");
        end

        // ALU writeback to x5 with same-cycle bypass on port 1.
        drive(1'b0, 1'b1, 1'b0, 64'h1111_2222_3333_4444, 64'h1234_5678_9ABC_DEF0, 5'd5, 5'd5, 5'd6);
        expect_val(S_RD1, 64'h1234_5678_9ABC_DEF0, "bypass_rd1_x5");
        expect_val(S_RD2, 64'd0, "rd2_x6_untouched");
        expect_val(S_WB,  64'h1234_5678_9ABC_DEF0, "wbdata_alu");
        expect_val(S_CNT, 64'd0, "cnt_before_first_commit");

        drive(1'b0, 1'b0, 1'b0, '0, '0, 5'd0, 5'd0, 5'd5);
        expect_val(S_RD2, 64'h1234_5678_9ABC_DEF0, "stored_rd2_x5");
        expect_val(S_RD1, 64'd0, "rd1_x0");
        expect_val(S_CNT, 64'd1, "cnt_after_first_commit");

        // Load writeback to x31.
        drive(1'b0, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'h5, 5'd31, 5'd31, 5'd5);
        expect_val(S_WB,   64'hDEAD_BEEF_0000_0001, "wbdata_mem");
        expect_val(S_RD1,  64'hDEAD_BEEF_0000_0001, "bypass_rd1_x31");
        expect_val(S_RD2,  64'h1234_5678_9ABC_DEF0, "rd2_x5_during_write");
        expect_val(S_RD1N, 64'hDEAD_BEEF_0000_0001, "narrow_bypass_rd1_x31");
        expect_val(S_RD2N, 64'h1234_5678_9ABC_DEF0, "narrow_rd2_x5");
        expect_val(S_WBN,  64'hDEAD_BEEF_0000_0001, "narrow_wbdata_mem");

        drive(1'b0, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h5, 5'd31, 5'd31, 5'd31);
        expect_val(S_RD1, 64'hDEAD_BEEF_0000_0001, "stored_rd1_x31");
        expect_val(S_RD2, 64'hDEAD_BEEF_0000_0001, "stored_rd2_x31");
        expect_val(S_WB,  64'h5, "wbdata_alu_no_write");
        expect_val(S_CNT, 64'd2, "cnt_after_x31");

        // Write to x0 is discarded, including on the bypass path.
        drive(1'b0, 1'b1, 1'b0, '0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0, 5'd0);
        expect_val(S_RD1, 64'd0, "x0_bypass_rd1");
        expect_val(S_RD2, 64'd0, "x0_bypass_rd2");
        expect_val(S_WB,  64'hFFFF_FFFF_FFFF_FFFF, "wbdata_x0_write");

        drive(1'b0, 1'b0, 1'b0, '0, '0, 5'd0, 5'd0, 5'd0);
        expect_val(S_RD1, 64'd0, "x0_stored_rd1");
        expect_val(S_CNT, 64'd2, "cnt_unchanged_x0");

        // Both ports bypass the same destination.
        drive(1'b0, 1'b1, 1'b0, '0, 64'h0123_4567_89AB_CDEF, 5'd9, 5'd9, 5'd9);
        expect_val(S_RD1, 64'h0123_4567_89AB_CDEF, "dual_bypass_rd1");
        expect_val(S_RD2, 64'h0123_4567_89AB_CDEF, "dual_bypass_rd2");
        expect_val(S_CNT, 64'd2, "cnt_before_x9");

        // x7 = 0xA, then reset collides with a write of 0xB to x7.
        drive(1'b0, 1'b1, 1'b0, '0, 64'hA, 5'd7, 5'd7, 5'd0);
        expect_val(S_RD1, 64'hA, "bypass_x7_a");
        expect_val(S_CNT, 64'd3, "cnt_before_x7");

        drive(1'b0, 1'b0, 1'b0, '0, 64'hA, 5'd7, 5'd7, 5'd9);
        expect_val(S_RD1, 64'hA, "stored_x7_a");
        expect_val(S_RD2, 64'h0123_4567_89AB_CDEF, "stored_x9");
        expect_val(S_CNT, 64'd4, "cnt_before_reset");

        drive(1'b1, 1'b1, 1'b0, '0, 64'hB, 5'd7, 5'd7, 5'd9);
        expect_val(S_RD1, 64'hA, "no_bypass_in_reset");
        expect_val(S_WB,  64'hB, "wbdata_in_reset");
        expect_val(S_CNT, 64'd4, "cnt_during_reset");

        drive(1'b0, 1'b0, 1'b0, '0, 64'hB, 5'd7, 5'd7, 5'd9);
        expect_val(S_RD1, 64'd0, "x7_cleared_not_b");
        expect_val(S_RD2, 64'd0, "x9_cleared");
        expect_val(S_CNT, 64'd0, "cnt_cleared");
        expect_val(S_CNTN, 64'd0, "narrow_cnt_cleared");

        // First commit after reset, then a non-committing cycle with Rs == Rd.
        drive(1'b0, 1'b1, 1'b0, '0, 64'd77, 5'd3, 5'd3, 5'd7);
        expect_val(S_RD1, 64'd77, "bypass_after_reset");
        expect_val(S_RD2, 64'd0, "x7_still_zero");

        drive(1'b0, 1'b0, 1'b0, '0, 64'd99, 5'd3, 5'd3, 5'd0);
        expect_val(S_RD1, 64'd77, "no_bypass_without_regwrite");
        expect_val(S_CNT, 64'd1, "cnt_first_after_reset");

        // Drive counters to 15, then one more commit wraps the 4-bit counter.
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, 1'b1, 1'b0, '0, 64'(i), 5'd10, 5'd0, 5'd0);
        end
        drive(1'b0, 1'b1, 1'b0, '0, 64'd200, 5'd10, 5'd10, 5'd0);
        expect_val(S_CNT,  64'd15, "cnt_at_15");
        expect_val(S_CNTN, 64'd15, "narrow_cnt_all_ones");
        expect_val(S_RD1,  64'd200, "bypass_x10");

        drive(1'b0, 1'b0, 1'b0, '0, '0, 5'd0, 5'd10, 5'd0);
        expect_val(S_CNT,  64'd16, "cnt_at_16");
        expect_val(S_CNTN, 64'd0, "narrow_cnt_wrap");
        expect_val(S_RD1,  64'd200, "stored_x10");

        @(posedge clk);
        @(posedge clk);
        #1;

        n_tests++;
        if (WbCount !== 32'd16) begin
            n_fail++;
            $display("FAIL final_cnt: got %0d expected 16", WbCount);
        end
        n_tests++;
        if (WbCount_n !== 4'd0) begin
            n_fail++;
            $display("FAIL final_narrow_cnt: got %0d expected 0", WbCount_n);
        end
        n_tests++;
        if (ReadData1 !== 64'd200) begin
            n_fail++;
            $display("FAIL final_rd1_x10: got %h expected %h", ReadData1, 64'd200);
        end
        n_tests++;
        if (ReadData2 !== 64'd0) begin
            n_fail++;
            $display("FAIL final_rd2_x0: got %h expected 0", ReadData2);
        end
        n_tests++;
        if (WbData !== 64'd0) begin
            n_fail++;
            $display("FAIL final_wbdata: got %h expected 0", WbData);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        if (n_fail == 0) $display("PASS");
        else $display("FAIL");
        $finish;
    end

endmodule
